// File: rtl/io_mem_port.sv
// Z80 I/O-mapped window into an external memory: address/control registers plus a DATA port
// that issues req/ack memory transactions with optional address auto-step and CPU WAIT.
module io_mem_port #(
    parameter int BASE_PORT    = 200,
    parameter int ADDR_W       = 16,
    parameter bit AUTO_INC_RST = 1'b1
) (
    input  logic              sys_clock,
    input  logic              RESET,
    input  logic              cpu_ena,
    input  logic [7:0]        A,
    input  logic [7:0]        cpu_dout,
    input  logic              IORQ,
    input  logic              RD,
    input  logic              WR,
    input  logic              M1,
    output logic [7:0]        dout,
    output logic              hit,
    output logic              WAIT,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_din,
    input  logic [7:0]        mem_dout,
    output logic              mem_rd,
    output logic              mem_wr,
    input  logic              mem_ack
);

    localparam logic [7:0]        BASE = BASE_PORT[7:0];
    localparam logic [ADDR_W-1:0] ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, WR_REQ, RD_REQ, RD_HOLD} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [7:0]        off;
    logic              is_data;
    logic              served;
    logic              start;
    logic              data_wr_start;
    logic              data_rd_start;
    logic              reg_wr_start;
    logic              busy;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] addr_wr;
    logic [ADDR_W-1:0] addr_step;
    logic [23:0]       addr_ext;
    logic              inc_en;
    logic              dec_dir;
    logic [7:0]        rdata;
    logic [7:0]        ctrl_rd;

    // Offset arithmetic wraps in 8 bits, so the window test is a single compare.
    assign off     = A - BASE;
    assign is_data = (off == 8'd3);
    assign hit     = IORQ & (RD | WR) & ~M1 & (off < 8'd5);

    // served marks that this CPU I/O cycle already produced its one action.
    assign start         = cpu_ena & hit & ~served & (state == IDLE);
    assign data_wr_start = start & WR & is_data;
    assign data_rd_start = start & ~WR & RD & is_data;
    assign reg_wr_start  = start & WR & ~is_data;

    always_ff @(posedge sys_clock) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (data_wr_start) begin
                    state_nxt = WR_REQ;
                end else if (data_rd_start) begin
                    state_nxt = RD_REQ;
                end
            end
            WR_REQ:  if (mem_ack) state_nxt = IDLE;
            RD_REQ:  if (mem_ack) state_nxt = RD_HOLD;
            RD_HOLD: if (cpu_ena && !hit) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem_rd = (state == RD_REQ);
        mem_wr = (state == WR_REQ);
        busy   = mem_rd | mem_wr;
        WAIT   = hit & ((is_data & RD & (state != RD_HOLD)) |
                        (WR & (state == WR_REQ)) |
                        (WR & ~is_data & (state != IDLE)));
    end

    always_comb begin
        addr_ext             = '0;
        addr_ext[ADDR_W-1:0] = addr;
        addr_step            = addr;
        if (inc_en) begin
            addr_step = dec_dir ? (addr - ONE) : (addr + ONE);
        end
        // Byte lane write; bits at or above ADDR_W simply do not exist.
        addr_wr = addr;
        for (int i = 0; i < ADDR_W; i++) begin
            if ((i / 8) == int'(off)) begin
                addr_wr[i] = cpu_dout[i % 8];
            end
        end
    end

    always_ff @(posedge sys_clock) begin
        if (RESET) begin
            addr    <= '0;
            inc_en  <= AUTO_INC_RST;
            dec_dir <= 1'b0;
            mem_din <= 8'h00;
            rdata   <= 8'h00;
            served  <= 1'b0;
        end else begin
            if (cpu_ena) begin
                if (!hit) begin
                    served <= 1'b0;
                end else if (start) begin
                    served <= 1'b1;
                end
            end
            if (data_wr_start) begin
                mem_din <= cpu_dout;
            end
            if (reg_wr_start) begin
                if (off == 8'd4) begin
                    inc_en  <= cpu_dout[0];
                    dec_dir <= cpu_dout[1];
                end else begin
                    addr <= addr_wr;
                end
            end
            if (busy && mem_ack) begin
                addr <= addr_step;
            end
            if ((state == RD_REQ) && mem_ack) begin
                rdata <= mem_dout;
            end
        end
    end

    assign mem_addr = addr;
    assign ctrl_rd  = {busy, 5'b00000, dec_dir, inc_en};

    always_comb begin
        dout = 8'hFF;
        if (hit) begin
            case (off)
                8'd0:    dout = addr_ext[7:0];
                8'd1:    dout = addr_ext[15:8];
                8'd2:    dout = addr_ext[23:16];
                8'd3:    dout = rdata;
                8'd4:    dout = ctrl_rd;
                default: dout = 8'hFF;
            endcase
        end
    end

endmodule

// File: tb/tb_io_mem_port.sv
// Directed bench for io_mem_port: CPU I/O cycles on a divided cpu_ena, a delayed-ack memory
// responder with an expected-request queue, and hand-computed register/address checks.
module tb_io_mem_port;

    logic        sys_clock = 1'b0;
    logic        RESET     = 1'b1;
    logic        cpu_ena   = 1'b0;
    logic [7:0]  A         = 8'h00;
    logic [7:0]  cpu_dout  = 8'h00;
    logic        IORQ      = 1'b0;
    logic        RD        = 1'b0;
    logic        WR        = 1'b0;
    logic        M1        = 1'b0;
    logic [7:0]  dout;
    logic        hit;
    logic        WAIT;
    logic [15:0] mem_addr;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout  = 8'h00;
    logic        mem_rd;
    logic        mem_wr;
    logic        mem_ack   = 1'b0;

    io_mem_port #(.BASE_PORT(200), .ADDR_W(16), .AUTO_INC_RST(1'b1)) dut (
        .sys_clock(sys_clock), .RESET(RESET), .cpu_ena(cpu_ena), .A(A), .cpu_dout(cpu_dout),
        .IORQ(IORQ), .RD(RD), .WR(WR), .M1(M1), .dout(dout), .hit(hit), .WAIT(WAIT),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout), .mem_rd(mem_rd),
        .mem_wr(mem_wr), .mem_ack(mem_ack)
    );

    // Clock / reset block: cpu_ena is high on every other sys_clock edge.
    always #5 sys_clock = ~sys_clock;
    always @(posedge sys_clock) cpu_ena <= ~cpu_ena;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Memory responder and scoreboard: entries are {is_write, addr, write data or 0}.
    logic [24:0] exp_q[$];
    bit          mem_auto   = 1'b0;
    bit          stray_ack  = 1'b0;
    int          ack_delay  = 1;
    logic [7:0]  rd_value   = 8'h00;
    int          req_cycles = 0;
    int          hi_cnt     = 0;
    int          rises      = 0;
    logic        req_d      = 1'b0;

    always @(negedge sys_clock) begin
        logic [24:0] e;
        mem_ack = 1'b0;
        if (mem_wr) hi_cnt++;
        if ((mem_rd || mem_wr) && !req_d) rises++;
        req_d = mem_rd | mem_wr;
        if (stray_ack) begin
            mem_ack   = 1'b1;
            mem_dout  = 8'hEE;
            stray_ack = 1'b0;
        end else if (mem_auto && (mem_rd || mem_wr)) begin
            req_cycles++;
            if (req_cycles >= ack_delay) begin
                mem_ack    = 1'b1;
                mem_dout   = rd_value;
                req_cycles = 0;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL req_unexpected: got wr=%0b addr=%0h, queue empty", mem_wr, mem_addr);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("mem_req", {mem_wr, mem_addr, (mem_wr ? mem_din : 8'h00)}, e);
                    if (mem_rd) check_eq("wait_at_ack", WAIT, 1);
                end
            end
        end else begin
            req_cycles = 0;
        end
    end

    // Driver tasks: one Z80 I/O cycle lasting min_edges non-WAIT cpu_ena edges.
    task automatic io_cycle(input logic [7:0] port, input bit is_wr, input logic [7:0] wdata,
                            input int min_edges, output logic [7:0] rdata, output int waited);
        int n     = 0;
        int guard = 0;
        waited = 0;
        rdata  = 8'h00;
        A = port; cpu_dout = wdata; IORQ = 1'b1; M1 = 1'b0; RD = !is_wr; WR = is_wr;
        while (n < min_edges && guard < 300) begin
            @(negedge sys_clock);
            guard++;
            if (cpu_ena) begin
                if (WAIT) begin
                    waited++;
                end else begin
                    n++;
                    rdata = dout;
                end
            end
        end
        check_eq("io_cycle_done", n, min_edges);
        @(posedge sys_clock);
        #1;
        IORQ = 1'b0; RD = 1'b0; WR = 1'b0;
        repeat (4) @(posedge sys_clock);
        #1;
    endtask

    task automatic io_wr(input logic [7:0] port, input logic [7:0] data);
        logic [7:0] d;
        int w;
        io_cycle(port, 1'b1, data, 1, d, w);
    endtask

    task automatic io_rd(input logic [7:0] port, output logic [7:0] data);
        int w;
        io_cycle(port, 1'b0, 8'h00, 1, data, w);
    endtask

    task automatic wait_idle();
        int guard = 0;
        while ((mem_rd || mem_wr) && guard < 200) begin
            @(negedge sys_clock);
            guard++;
        end
        check_eq("idle_reached", {mem_rd, mem_wr}, 0);
    endtask

    initial begin
        logic [7:0] d;
        int w;
        int base;
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        int w;
        int base;
        repeat (4) @(posedge sys_clock);
        #1 RESET = 1'b0;
        @(negedge sys_clock);
        check_eq("rst_mem_rd", mem_rd, 0);
        check_eq("rst_mem_wr", mem_wr, 0);
        check_eq("rst_wait", WAIT, 0);
        check_eq("rst_hit", hit, 0);
        check_eq("rst_dout", dout, 8'hFF);
        check_eq("rst_addr", mem_addr, 16'h0000);
        check_eq("rst_din", mem_din, 8'h00);
        @(posedge sys_clock);
        #1;
        mem_auto = 1'b1;

        // Address registers: no memory traffic, readback, upper byte ignored for ADDR_W=16.
        base = rises;
        io_wr(8'd200, 8'h34);
        io_wr(8'd201, 8'h12);
        io_wr(8'd202, 8'h7F);
        io_rd(8'd200, d); check_eq("addr_lo_rd", d, 8'h34);
        io_rd(8'd201, d); check_eq("addr_hi_rd", d, 8'h12);
        io_rd(8'd202, d); check_eq("addr_top_rd", d, 8'h00);
        io_rd(8'd204, d); check_eq("ctrl_rst_rd", d, 8'h01);
        check_eq("mem_addr_1234", mem_addr, 16'h1234);
        check_eq("no_req_pulse", rises - base, 0);

        // DATA write at 0xFFFF with auto-increment: wraps to 0.
        io_wr(8'd200, 8'hFF);
        io_wr(8'd201, 8'hFF);
        io_wr(8'd204, 8'h01);
        ack_delay = 3;
        exp_q.push_back({1'b1, 16'hFFFF, 8'hA5});
        base = hi_cnt;
        io_wr(8'd203, 8'hA5);
        wait_idle();
        check_eq("wr_high_cycles", hi_cnt - base, 3);
        check_eq("wr_din", mem_din, 8'hA5);
        check_eq("wr_wrap_addr", mem_addr, 16'h0000);

        // DATA read at 0x0100: WAIT until ack, data held, address steps.
        io_wr(8'd200, 8'h00);
        io_wr(8'd201, 8'h01);
        ack_delay = 4;
        rd_value  = 8'h5A;
        exp_q.push_back({1'b0, 16'h0100, 8'h00});
        io_cycle(8'd203, 1'b0, 8'h00, 1, d, w);
        check_eq("rd_data", d, 8'h5A);
        check_eq("rd_waited", (w > 0), 1);
        check_eq("rd_wait_clear", WAIT, 0);
        io_rd(8'd200, d); check_eq("rd_step_lo", d, 8'h01);
        io_rd(8'd201, d); check_eq("rd_step_hi", d, 8'h01);

        // Decrement mode from 0x0000: 0x0000, 0xFFFF, then 0xFFFE.
        io_wr(8'd200, 8'h00);
        io_wr(8'd201, 8'h00);
        io_wr(8'd204, 8'h03);
        ack_delay = 2;
        exp_q.push_back({1'b0, 16'h0000, 8'h00});
        exp_q.push_back({1'b0, 16'hFFFF, 8'h00});
        rd_value = 8'h77;
        io_rd(8'd203, d); check_eq("dec_rd0", d, 8'h77);
        rd_value = 8'hC3;
        io_rd(8'd203, d); check_eq("dec_rd1", d, 8'hC3);
        io_rd(8'd200, d); check_eq("dec_lo", d, 8'hFE);
        io_rd(8'd201, d); check_eq("dec_hi", d, 8'hFF);
        io_rd(8'd204, d); check_eq("ctrl_03", d, 8'h03);

        // Back-to-back DATA writes with a slow memory.
        io_wr(8'd204, 8'h01);
        io_wr(8'd200, 8'h10);
        io_wr(8'd201, 8'h00);
        ack_delay = 10;
        exp_q.push_back({1'b1, 16'h0010, 8'hC1});
        exp_q.push_back({1'b1, 16'h0011, 8'hC2});
        base = rises;
        io_wr(8'd203, 8'hC1);
        io_cycle(8'd203, 1'b1, 8'hC2, 1, d, w);
        check_eq("b2b_waited", (w > 0), 1);
        wait_idle();
        check_eq("b2b_req_count", rises - base, 2);
        check_eq("b2b_queue_empty", exp_q.size(), 0);
        io_rd(8'd200, d); check_eq("b2b_addr", d, 8'h12);

        // Reset during RD_REQ, then a stray ack.
        mem_auto = 1'b0;
        io_wr(8'd200, 8'h05);
        A = 8'd203; IORQ = 1'b1; RD = 1'b1; WR = 1'b0; M1 = 1'b0;
        w = 0;
        while (!mem_rd && w < 50) begin
            @(negedge sys_clock);
            w++;
        end
        check_eq("rd_req_seen", mem_rd, 1);
        RESET = 1'b1; IORQ = 1'b0; RD = 1'b0;
        @(negedge sys_clock);
        check_eq("rst_rd_drop", mem_rd, 0);
        check_eq("rst_wait_drop", WAIT, 0);
        RESET = 1'b0;
        @(posedge sys_clock);
        #1 stray_ack = 1'b1;
        base = rises;
        repeat (3) @(negedge sys_clock);
        check_eq("stray_no_req", {mem_rd, mem_wr}, 0);
        @(posedge sys_clock);
        #1;
        io_rd(8'd200, d); check_eq("stray_addr", d, 8'h00);
        io_rd(8'd204, d); check_eq("stray_ctrl", d, 8'h01);
        io_wr(8'd200, 8'h42);
        io_rd(8'd200, d); check_eq("post_rst_wr", d, 8'h42);

        // Interrupt acknowledge cycle is never decoded.
        A = 8'd203; IORQ = 1'b1; M1 = 1'b1; RD = 1'b1;
        @(negedge sys_clock);
        check_eq("inta_hit", hit, 0);
        check_eq("inta_dout", dout, 8'hFF);
        repeat (6) @(negedge sys_clock);
        check_eq("inta_no_rd", mem_rd, 0);
        check_eq("inta_wait", WAIT, 0);
        check_eq("inta_no_req", rises - base, 0);
        IORQ = 1'b0; M1 = 1'b0; RD = 1'b0;
        repeat (2) @(posedge sys_clock);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/io_mem_port.md
Name: io_mem_port

Overview:
Parametrised Z80 I/O-mapped window into an external memory (SDRAM or BRAM). It generalises the fixed three-port SDRAM test hook in the lm80c top level into a reusable block with these additions:
- wider address
- auto-increment/decrement
- a req/ack memory handshake
- WAIT generation toward the CPU

It sits beside the address decoder. Its dout is muxed into cpu_din whenever hit is high.

Parameters:
BASE_PORT, 200, 8-bit I/O base address; the block decodes BASE_PORT..BASE_PORT+4.
ADDR_W, 16, external address width, legal range 9..24.
AUTO_INC_RST, 1, reset value of CTRL.bit0 (auto-increment enable).

Ports:
sys_clock  in  1  system clock
RESET  in  1  synchronous, active-high reset
cpu_ena  in  1  Z80 clock enable; CPU-side signals are sampled only when high
A  in  8  CPU address low byte
cpu_dout  in  8  CPU write data
IORQ  in  1  active-high I/O request
RD  in  1  active-high read
WR  in  1  active-high write
M1  in  1  active-high M1; IORQ&M1 (interrupt acknowledge) is never decoded
dout  out  8  read data to the CPU mux
hit  out  1  combinational: IORQ & (RD|WR) & ~M1 & A in [BASE_PORT, BASE_PORT+4]
WAIT  out  1  active-high wait request to the CPU
mem_addr  out  ADDR_W  external address
mem_din  out  8  external write data
mem_dout  in  8  external read data, valid when mem_ack is high
mem_rd  out  1  read request, level
mem_wr  out  1  write request, level
mem_ack  in  1  one-cycle completion strobe from memory

Behaviour:
Register map, as offsets from BASE_PORT:
- 0 ADDR[7:0], read/write
- 1 ADDR[15:8], read/write
- 2 ADDR[23:16], read/write; bits at or above ADDR_W are write-ignored and read as 0
- 3 DATA
- 4 CTRL: bit0 auto-increment enable; bit1 decrement direction; bit7 busy (read-only); other bits read 0

Access start:
- An access "starts" at a sys_clock edge where cpu_ena=1, hit=1, and the previous cpu_ena sample had hit=0.
- Exactly one action is taken per CPU I/O cycle, however many cpu_ena edges that cycle spans.

State machine (all transitions on sys_clock):
- IDLE
  - A DATA write start latches mem_din<=cpu_dout and sets mem_wr=1 → WR_REQ.
  - A DATA read start sets mem_rd=1 → RD_REQ.
  - Writes to offsets 0-2 and 4 update the register immediately and stay in IDLE.
- WR_REQ: on mem_ack, mem_wr<=0, address step applied → IDLE.
- RD_REQ: on mem_ack, rdata<=mem_dout, mem_rd<=0, address step applied → RD_HOLD.
- RD_HOLD: rdata is held until hit falls, sampled on a cpu_ena edge → IDLE.

Address step (applied only if CTRL.bit0=1):
- ADDR ± 1, with direction set by CTRL.bit1.
- Arithmetic is modulo 2^ADDR_W: ADDR max + 1 wraps to 0, and 0 − 1 wraps to max.

WAIT (combinational):
- High when hit & A==BASE_PORT+3 & RD & state!=RD_HOLD.
- High when hit & WR & state==WR_REQ (a back-to-back write stalls until the prior write is acked).
- High when hit & A is an offset 0-2 or 4 write & state!=IDLE.
- A start that coincides with a held WAIT is deferred; it is re-evaluated every cpu_ena edge until the state is IDLE.

dout:
- Offsets 0-2, 4: current register value.
- Offset 3: rdata.
- Not hit: 8'hFF.

Timing:
- mem_addr is constant while mem_rd or mem_wr is high.
- Address-register writes from the CPU never alter mem_addr during a request, because of the WAIT rule above.
- mem_ack arriving while in IDLE or RD_HOLD is ignored.
- mem_ack in the same cycle the request rises is legal and completes the request.

RESET:
- Returns the block to IDLE with ADDR=0, CTRL=AUTO_INC_RST, mem_rd=0, mem_wr=0, mem_din=0, rdata=0.
- WAIT becomes 0 unless a new DATA read is present after reset.
- A request pending at reset is abandoned; a later stray mem_ack is ignored.

Test Plan:
- Write 8'h34 to port 200 and 8'h12 to port 201, then read both back → dout=8'h34 then 8'h12; mem_addr=16'h1234; no mem_rd/mem_wr pulse.
- ADDR=16'hFFFF, CTRL=8'h01, write 8'hA5 to port 203, memory acks after 3 cycles → mem_wr high exactly until ack with mem_din=8'hA5, then ADDR=16'h0000 (wrap).
- Read port 203 with ADDR=16'h0100, memory returns 8'h5A after 4 cycles → WAIT high until ack, dout=8'h5A for the rest of the I/O cycle, then ADDR=16'h0101.
- CTRL=8'h03, two consecutive DATA reads from ADDR=16'h0000 → mem_addr 16'h0000 then 16'hFFFF; final ADDR=16'hFFFE.
- Back-to-back DATA writes with ack delayed 10 cycles → the second write is held by WAIT and mem_wr for the second write rises only after the first ack; both writes complete.
- RESET asserted while in RD_REQ, then a mem_ack delivered → mem_rd=0 on the next edge, state IDLE, ADDR=0, the stray ack causes no change; an IORQ&M1 cycle with A=203 → hit=0, no request.
